// File: rtl/ece178_led_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear, per-bit blink mode and a
// programmable blink half-period shared by all blinking bits.
module ece178_led_pio_blink #(
  parameter int unsigned WIDTH       = 9,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0]      ResetData = RESET_VALUE[WIDTH-1:0];
  localparam logic [PRESCALE_W-1:0] CountOne  = PRESCALE_W'(1);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrMode   = 3'd1;
  localparam logic [2:0] AddrPeriod = 3'd2;
  localparam logic [2:0] AddrSet    = 3'd3;
  localparam logic [2:0] AddrClear  = 3'd4;
  localparam logic [2:0] AddrStatus = 3'd5;

  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] count_q, count_d;
  logic                  phase_q, phase_d;

  logic                  wr_en;
  logic                  period_wr;
  logic [63:0]           status_wide;
  logic                  unused_bits;

  assign wr_en     = chipselect & ~write_n;
  assign period_wr = wr_en && (address == AddrPeriod);

  // Register-file next state; one write per cycle, so no collisions to resolve.
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        AddrData:   data_d   = writedata[WIDTH-1:0];
        AddrMode:   mode_d   = writedata[WIDTH-1:0];
        AddrPeriod: period_d = writedata[PRESCALE_W-1:0];
        AddrSet:    data_d   = data_q | writedata[WIDTH-1:0];
        AddrClear:  data_d   = data_q & ~writedata[WIDTH-1:0];
        default:    ;
      endcase
    end
  end

  // Blink engine: a PERIOD write restarts the half-period ahead of any wrap.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (period_wr || (period_q == '0)) begin
      count_d = '0;
      phase_d = 1'b1;
    end else if (count_q == period_q - CountOne) begin
      count_d = '0;
      phase_d = ~phase_q;
    end else begin
      count_d = count_q + CountOne;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= ResetData;
      mode_q   <= '0;
      period_q <= '0;
      count_q  <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
    end
  end

  // STATUS packs {counter, phase}; anything past bit 31 is dropped.
  assign status_wide = 64'({count_q, phase_q});

  // Combinational read mux, zero-extended, no side effects.
  always_comb begin
    readdata = 32'h0;
    case (address)
      AddrData:   readdata = 32'(data_q);
      AddrMode:   readdata = 32'(mode_q);
      AddrPeriod: readdata = 32'(period_q);
      AddrStatus: readdata = status_wide[31:0];
      default:    readdata = 32'h0;
    endcase
  end

  // Output drive built only from registered terms.
  assign out_port = data_q & (~mode_q | {WIDTH{phase_q}});

  // Upper writedata bits and high status bits are intentionally discarded.
  assign unused_bits = ^{writedata, status_wide[63:32]};

endmodule

// File: tb/tb_ece178_led_pio_blink.sv
// Randomized self-checking bench for ece178_led_pio_blink against a
// behavioural model that derives counter/phase from elapsed cycles.
module tb_ece178_led_pio_blink;

  localparam int unsigned W  = 9;
  localparam int unsigned PW = 24;
  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] DMask = (32'h1 << W) - 32'h1;
  localparam logic [31:0] PMask = (32'h1 << PW) - 32'h1;

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_vec;
  int n_err;

  // Model state: registers plus cycles elapsed since the last PERIOD write.
  logic [31:0] m_data;
  logic [31:0] m_mode;
  logic [31:0] m_period;
  int unsigned m_t;

  ece178_led_pio_blink #(
    .WIDTH       (W),
    .RESET_VALUE (RV),
    .PRESCALE_W  (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_count();
    return (m_period == 0) ? 32'h0 : 32'(m_t % m_period);
  endfunction

  function automatic logic m_phase();
    return (m_period == 0) ? 1'b1 : (((m_t / m_period) % 2) == 0);
  endfunction

  function automatic logic [31:0] m_out();
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < W; i++) begin
      r[i] = m_data[i] && (!m_mode[i] || m_phase());
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return m_mode;
      3'd2:    return m_period;
      3'd5:    return (m_count() << 1) | 32'(m_phase());
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_data   = RV & DMask;
    m_mode   = 32'h0;
    m_period = 32'h0;
    m_t      = 0;
  endtask

  // One clock: drive a write or an idle bus, step the model, then check the
  // pins and a read of the address given (random when rd_addr is 8 or more).
  task automatic cycle(input logic we, input logic [2:0] a, input logic [31:0] wd,
                       input int rd_addr);
    if (we) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
    end else if ($urandom_range(0, 1) == 0) begin
      chipselect = 1'b0;
      write_n    = 1'b0;
    end else begin
      chipselect = 1'b1;
      write_n    = 1'b1;
    end
    address   = a;
    writedata = wd;
    @(posedge clk);
    if (we) begin
      case (a)
        3'd0: m_data = wd & DMask;
        3'd1: m_mode = wd & DMask;
        3'd2: begin m_period = wd & PMask; m_t = 0; end
        3'd3: m_data = m_data | (wd & DMask);
        3'd4: m_data = m_data & ~(wd & DMask);
        default: m_t++;
      endcase
      if (a != 3'd2 && a <= 3'd4) m_t++;
    end else begin
      m_t++;
    end
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
    address    = (rd_addr >= 8) ? 3'($urandom_range(0, 7)) : 3'(rd_addr);
    #1;
    check("out_port", 32'(out_port), m_out());
    check($sformatf("read%0d", address), readdata, m_read(address));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b1, a, wd, 32);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, 32);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    m_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_out", 32'(out_port), RV & DMask);
    address = 3'd0; #1; check("rst_data", readdata, 32'h0);
    address = 3'd1; #1; check("rst_mode", readdata, 32'h0);
    address = 3'd2; #1; check("rst_period", readdata, 32'h0);
    address = 3'd5; #1; check("rst_status", readdata, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // DATA write, truncation, set/clear.
    wr(3'd0, 32'h0000_01A5);
    check("data_1a5", 32'(out_port), 32'h1A5);
    address = 3'd0; #1; check("rd_data_1a5", readdata, 32'h1A5);
    wr(3'd0, 32'hFFFF_FFFF);
    check("data_ff", 32'(out_port), 32'h1FF);
    wr(3'd0, 32'h0000_01A5);
    wr(3'd3, 32'h0000_0002);
    check("outset", 32'(out_port), 32'h1A7);
    wr(3'd4, 32'h0000_0100);
    check("outclear", 32'(out_port), 32'h0A7);
    address = 3'd3; #1; check("rd_outset", readdata, 32'h0);
    address = 3'd4; #1; check("rd_outclear", readdata, 32'h0);

    // Blink with half-period 4.
    wr(3'd0, 32'h3);
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h4);
    for (int k = 1; k < 17; k++) begin
      cycle(1'b0, 3'd0, 32'h0, 5);
      check("blink_b0", 32'(out_port[0]), 32'(((k / 4) % 2) == 0));
      check("blink_b1", 32'(out_port[1]), 32'h1);
      check("blink_cnt", 32'(readdata[PW:1]), 32'(k % 4));
    end

    // PERIOD = 0 mid-blink, then PERIOD write coincident with a wrap.
    idle(5);
    wr(3'd2, 32'h0);
    idle(6);
    check("p0_out", 32'(out_port), 32'h3);
    for (int g = 0; g < 20 && m_count() != 32'd3; g++) idle(1);
    wr(3'd2, 32'h4);
    for (int g = 0; g < 20 && m_count() != 32'd3; g++) idle(1);
    check("pre_wrap_cnt", m_count(), 32'd3);
    wr(3'd2, 32'h2);
    address = 3'd5; #1; check("wrap_status", readdata, 32'h1);
    idle(8);

    // PERIOD = 1 toggles every cycle.
    wr(3'd2, 32'h1);
    idle(6);

    // Randomized traffic with small periods so blinking is visible.
    for (int n = 0; n < 1500; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      wr(3'd2, 32'($urandom_range(0, 6)) | ($urandom_range(0, 7) == 0 ? 32'hFF00_0000 : 32'h0));
      else if (sel <= 2) wr(3'($urandom_range(0, 1)), $urandom);
      else if (sel <= 4) wr(3'($urandom_range(3, 4)), $urandom);
      else if (sel == 5) wr(3'($urandom_range(5, 7)), $urandom);
      else               idle(1);
    end

    // Asynchronous reset mid-blink, between edges.
    wr(3'd0, 32'h1FF);
    wr(3'd1, 32'h0F0);
    wr(3'd2, 32'h3);
    idle(7);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    address = 3'd5;
    #1;
    m_reset();
    check("async_out", 32'(out_port), RV & DMask);
    check("async_status", readdata, 32'h1);
    #3;
    reset_n = 1'b1;
    wr(3'd0, 32'h0F0);
    wr(3'd1, 32'h0F0);
    idle(12);
    check("post_rst_steady", 32'(out_port), 32'h0F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
